// File: rtl/mdr_mem_if.sv
// Memory data register that owns the memory-side req/ack handshake.
// It supports sized, lane-aligned and extended transfers, and detects misalignment and ack timeouts.
module mdr_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  parameter int TO_W       = 4
) (
  input  logic                              clock,
  input  logic                              clear,
  input  logic [DATA_WIDTH-1:0]             bus_in,
  input  logic                              MDRin,
  input  logic                              MDRout,
  output logic [DATA_WIDTH-1:0]             bus_out,
  input  logic                              rd_start,
  input  logic                              wr_start,
  input  logic [1:0]                        size,
  input  logic                              sign_ext,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   offset,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [DATA_WIDTH/8-1:0]           mem_be,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  input  logic                              mem_ack,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [DATA_WIDTH-1:0]             mdr
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int OW = $clog2(BW);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t          state, next;
  logic [TO_W-1:0] cnt;
  logic [1:0]      size_q;
  logic            sext_q;
  logic [OW-1:0]   off_q;
  logic            start, legal, timeout;
  logic [BW-1:0]   be_new;
  logic [DATA_WIDTH-1:0] shifted, rd_ext;

  assign start   = rd_start ^ wr_start;
  assign legal   = (size == 2'b00) ||
                   (size == 2'b01 && !offset[0]) ||
                   (size == 2'b10 && offset == '0);
  assign timeout = (cnt == TO_W'(TIMEOUT - 1));
  assign busy    = (state == REQ) || (state == DONE);
  assign bus_out = MDRout ? mdr : '0;

  always_comb begin
    be_new = '1;
    case (size)
      2'b00:   be_new = BW'(1) << offset;
      2'b01:   be_new = BW'(3) << offset;
      default: be_new = '1;
    endcase
  end

  // Read path uses the offset/size/sign latched at start, so the inputs may change mid-transaction.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   rd_ext = {{(DATA_WIDTH-8){sext_q & shifted[7]}}, shifted[7:0]};
      2'b01:   rd_ext = {{(DATA_WIDTH-16){sext_q & shifted[15]}}, shifted[15:0]};
      default: rd_ext = shifted;
    endcase
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (start)                    next = legal ? REQ : ERR;
        else if (rd_start && wr_start) next = ERR;
      end
      REQ: begin
        if (mem_ack)      next = DONE;
        else if (timeout) next = ERR;
      end
      DONE:    next = IDLE;
      ERR:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= next;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mdr       <= '0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      size_q    <= 2'b00;
      sext_q    <= 1'b0;
      off_q     <= '0;
    end else begin
      done <= (next == DONE);
      case (state)
        IDLE: begin
          if (MDRin) mdr <= bus_in;
          if (start) err <= 1'b0;
          if (next == REQ) begin
            mem_req   <= 1'b1;
            mem_we    <= wr_start;
            mem_be    <= be_new;
            mem_wdata <= mdr << {offset, 3'b000};
            cnt       <= '0;
            size_q    <= size;
            sext_q    <= sign_ext;
            off_q     <= offset;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) mdr <= rd_ext;
          end else if (timeout) begin
            mem_req <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (next == ERR) err <= 1'b1;
    end
  end

endmodule

// File: doc/mdr_mem_if.md
Name: mdr_mem_if

Overview:
- Next-generation memory data register for the datapath: a parametrised MDR that owns the memory-side handshake.
- Holds one DATA_WIDTH word, loaded from the internal bus or from memory. Presents it to the bus or to memory.
- Runs a req/ack transaction FSM with byte/halfword/word sizing, lane alignment, sign/zero extension, misalignment detection and an ack timeout.
- Sits between the CPU bus and the memory subsystem, replacing the plain bidirectional MDR.

Parameters:
- DATA_WIDTH, 32, register and memory data width; multiple of 16, at least 32.
- TIMEOUT, 15, maximum cycles mem_req waits for mem_ack before aborting; range 1 to 2^TO_W-1.
- TO_W, 4, width of the timeout counter.

Ports:
- clock  in  1  single system clock, rising edge.
- clear  in  1  reset, asynchronous, active-low.
- bus_in  in  DATA_WIDTH  data from the internal bus.
- MDRin  in  1  load bus_in into the MDR.
- MDRout  in  1  drive the MDR onto bus_out.
- bus_out  out  DATA_WIDTH  equals mdr when MDRout=1, else 0.
- rd_start  in  1  start a memory read.
- wr_start  in  1  start a memory write.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  in  1  read only: 1 sign-extends, 0 zero-extends.
- offset  in  $clog2(DATA_WIDTH/8)  byte offset of the access.
- mem_req  out  1  transaction request.
- mem_we  out  1  1 for write, 0 for read.
- mem_be  out  DATA_WIDTH/8  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-aligned write data.
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack=1.
- mem_ack  in  1  memory completion.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag.
- mdr  out  DATA_WIDTH  current register value, for debug and observation.

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE; mdr, counter, mem_req, mem_we, mem_be, mem_wdata, done and err all 0.
  - Reset mid-transaction drops mem_req immediately. No done pulse is produced.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - MDRin=1 loads bus_in at the clock edge.
  - On rd_start XOR wr_start, at that edge:
    - clear err;
    - validate the access: size=11 is illegal; half with offset[0]=1 is illegal; word with offset!=0 is illegal;
    - if legal, go to REQ and register mem_req=1, mem_we=wr_start, mem_be and mem_wdata, and clear the counter;
    - if illegal, go to ERR with no request issued.
  - rd_start and wr_start together go to ERR.
  - MDRin together with rd_start: the bus value loads now, and the read result later overwrites it.
- Byte enables:
  - byte: the single bit at offset;
  - half: two bits starting at offset;
  - word: all ones.
- Write data: mdr shifted left by offset*8; lanes outside mem_be are don't-care.
- REQ:
  - mem_req, mem_we, mem_be and mem_wdata are held stable until mem_ack is sampled.
  - mem_ack=1 at an edge:
    - on a read, mdr <= extend(mask(mem_rdata >> offset*8));
    - drop mem_req and go to DONE.
  - Otherwise the counter increments. If counter==TIMEOUT-1 with no ack: drop mem_req, go to ERR, mdr unchanged.
  - A late ack arriving after the abort is ignored.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERR: err<=1 at entry, then IDLE next cycle. err stays high until the next accepted start or reset.
- busy=1 in REQ and DONE.
- While busy:
  - rd_start, wr_start and MDRin are ignored;
  - MDRout stays functional.
- mem_ack in IDLE, DONE or ERR is ignored.
- Read extension:
  - byte uses bit 7 as the sign bit;
  - half uses bit 15 as the sign bit;
  - word is passed through unchanged.
- Latency: start sampled at edge k; mem_req high after k. For an ack at edge k+1+w, done is high during the cycle after that edge.
- Zero-wait minimum: 3 cycles start-to-IDLE.

Test Plan:
- MDRin with bus_in=0xDEADBEEF, then MDRout=1 -> bus_out=0xDEADBEEF. With MDRout=0 -> bus_out=0.
- Word read, offset 0, mem_rdata=0x12345678, ack after 2 wait cycles -> mem_req high 3 cycles, mem_we=0, be=1111, mdr=0x12345678, one done pulse.
- Byte read, offset 2, mem_rdata=0x00F00000:
  - sign_ext=1 -> mdr=0xFFFFFFF0;
  - sign_ext=0 -> mdr=0x000000F0.
- Half write, offset 2, mdr=0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata[31:16]=0xABCD, held until ack.
- Half read offset 1, word write offset 2, and size=11 -> err=1, mem_req never asserted, mdr unchanged. The next legal start clears err.
- No ack with TIMEOUT=15 -> mem_req high exactly 15 cycles, then err=1 and no done. A late ack is ignored. Reset asserted mid-REQ -> mem_req=0 immediately and all outputs at reset values.
